uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
- Frame sequencer between the UART block (RX/TX FIFOs) and an external combinational ALU.
- Pulls a 3-byte command frame from the RX FIFO in the order A, B, OP.
- Presents the operands and opcode to the ALU on registered outputs, captures the result, and pushes one result byte into the TX FIFO.
- Sits at top level beside uart_top; uart_top is untouched.

Parameters:
- DBIT, 8, data/byte width; matches the UART DBIT.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the OP byte.
- TIMEOUT_TICKS, 50000, inter-byte timeout in i_clk cycles (used only with the optional feature).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_rx_empty  in  1  RX FIFO empty flag.
- i_r_data  in  DBIT  RX FIFO head word; show-ahead, valid while i_rx_empty=0.
- o_rd_uart  out  1  RX FIFO pop strobe.
- i_tx_full  in  1  TX FIFO full flag.
- o_wr_uart  out  1  TX FIFO push strobe.
- o_w_data  out  DBIT  TX FIFO write data.
- o_alu_a  out  DBIT  operand A (registered).
- o_alu_b  out  DBIT  operand B (registered).
- o_alu_op  out  NB_OP  opcode (registered).
- i_alu_result  in  DBIT  ALU result; combinational from o_alu_*.
- o_busy  out  1  high whenever state is not S_WAIT_A.

Behaviour:
- Reset (async, i_reset=1):
  - State goes to S_WAIT_A.
  - o_alu_a, o_alu_b, o_alu_op, o_w_data and the result register clear to 0.
  - o_rd_uart, o_wr_uart and o_busy are 0.
- States: S_WAIT_A -> S_WAIT_B -> S_WAIT_OP -> S_EXEC -> S_SEND -> S_WAIT_A.
- S_WAIT_A, S_WAIT_B, S_WAIT_OP:
  - o_rd_uart = !i_rx_empty (combinational, single cycle per byte).
  - On that same rising edge, i_r_data is latched into A, B, or OP[NB_OP-1:0] (upper OP bits discarded) and the state advances.
  - While i_rx_empty=1, hold state and keep o_rd_uart=0.
  - Exactly one pop per byte; no pop in any other state.
- S_EXEC: lasts exactly 1 cycle; registers i_alu_result into result_reg. The ALU sees stable registered operands for that full cycle.
- S_SEND:
  - o_wr_uart = !i_tx_full (combinational); o_w_data = result_reg.
  - On push, return to S_WAIT_A.
  - If i_tx_full=1, stall in S_SEND with o_wr_uart=0; no data loss and no RX pops.
- Latency, last byte available to TX push: 2 cycles minimum (pop edge -> S_EXEC -> push in S_SEND).
- Back-to-back frames: S_WAIT_A may pop in the cycle immediately after the push.
- o_alu_a/b/op hold their last frame's values until overwritten.
- Reset mid-frame: any partial frame is discarded. Bytes remaining in the RX FIFO are treated as the start of a new frame; the controller never flushes the FIFO.
- Strobes never assert while i_reset=1.

Optional Feature:
- Macro: UART_ALU_CTRL_TIMEOUT_EN.
- With the macro:
  - A counter clears on each pop and increments every cycle spent in S_WAIT_B or S_WAIT_OP with i_rx_empty=1.
  - When it reaches TIMEOUT_TICKS-1, the partial frame is dropped and the state returns to S_WAIT_A next cycle.
  - Operand registers are not cleared on timeout. The counter is held at 0 in all other states.
- Without the macro: no counter logic; the controller waits indefinitely for the remaining bytes.

Decomposition:
- Package uart_alu_ctrl_pkg holds:
  - state encoding localparams: S_WAIT_A=0, S_WAIT_B=1, S_WAIT_OP=2, S_EXEC=3, S_SEND=4, in 3 bits;
  - default DBIT/NB_OP values;
  - default TIMEOUT_TICKS.
- One sub-module, uart_alu_ctrl_timer (up-counter with clear/enable and a terminal flag), instantiated only under UART_ALU_CTRL_TIMEOUT_EN.
- FSM and datapath registers stay in the top module.

Test Plan:
- Frame 0x05,0x03,0x20 preloaded in the RX FIFO; ALU model returns 0x08 -> exactly 3 single-cycle o_rd_uart pulses; o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; one o_wr_uart pulse with o_w_data=0x08 two cycles after the third pop.
- Bytes 0xFF,0x01,0x20 arrive ~2604 cycles apart (serial rate) -> state holds during the gaps with o_rd_uart=0; o_w_data=0x00 (8-bit wrap of the ALU result).
- i_tx_full=1 for 100 cycles at S_SEND -> o_wr_uart=0 throughout, no RX pops; the single push of the correct result occurs the cycle i_tx_full falls.
- Two frames back-to-back in the FIFO -> 6 pops and 2 pushes in order; the first pop of frame 2 is the cycle after push 1.
- i_reset pulsed after A=0x11 is popped; then 0x22,0x33,0x20 supplied -> all outputs 0 during reset; the next frame decodes as A=0x22, B=0x33.
- With UART_ALU_CTRL_TIMEOUT_EN and TIMEOUT_TICKS=16: pop A then leave the FIFO empty -> return to S_WAIT_A after 16 cycles, no push; the next 3 bytes form a fresh frame.

Source files
------------

// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types and defaults for the UART <-> ALU frame sequencer.
// Optional inter-byte timeout is enabled with `define UART_ALU_CTRL_TIMEOUT_EN.
package uart_alu_ctrl_pkg;

  localparam int DEF_DBIT          = 8;
  localparam int DEF_NB_OP         = 6;
  localparam int DEF_TIMEOUT_TICKS = 50000;
  localparam int STATE_W           = 3;

  // Frame sequencer states; values are fixed so waveforms and debug taps stay stable.
  typedef enum logic [STATE_W-1:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4
  } state_e;

  // True in the states that may still be waiting on an RX byte mid-frame.
  function automatic logic is_mid_frame(state_e s);
    return (s == S_WAIT_B) || (s == S_WAIT_OP);
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the RX FIFO, TX FIFO and ALU signals seen by the frame sequencer.
// master = the sequencer, slave = the UART FIFOs and ALU around it.
interface uart_alu_ctrl_if
  import uart_alu_ctrl_pkg::*;
#(
  parameter int DBIT  = DEF_DBIT,
  parameter int NB_OP = DEF_NB_OP
);

  logic             i_rx_empty;
  logic [DBIT-1:0]  i_r_data;
  logic             o_rd_uart;
  logic             i_tx_full;
  logic             o_wr_uart;
  logic [DBIT-1:0]  o_w_data;
  logic [DBIT-1:0]  o_alu_a;
  logic [DBIT-1:0]  o_alu_b;
  logic [NB_OP-1:0] o_alu_op;
  logic [DBIT-1:0]  i_alu_result;
  logic             o_busy;

  modport master (
    input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    output o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op, o_busy
  );

  modport slave (
    output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    input  o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op, o_busy
  );

endinterface

// File: rtl/uart_alu_ctrl_timer.sv
// Inter-byte timeout counter: up-counter with synchronous clear, count enable
// and a terminal flag at TICKS-1. Only used when UART_ALU_CTRL_TIMEOUT_EN is set.
module uart_alu_ctrl_timer #(
  parameter  int TICKS = 16,
  localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  logic [CW-1:0] r_count;

  // Count enabled cycles; clear has priority so a pop restarts the window.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)    r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + CW'(1);
  end

  assign o_done = (r_count == CW'(TICKS - 1));

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops A, B, OP from the RX FIFO, drives the external ALU from
// registered operands, captures the result and pushes it to the TX FIFO.
// Optional inter-byte timeout: `define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int DBIT  = DEF_DBIT,
  parameter int NB_OP = DEF_NB_OP
`ifdef UART_ALU_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
`endif
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_alu_ctrl_if.master bus
);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_rd;
  logic             w_wr;
  logic             w_timeout;
  logic [DBIT-1:0]  r_a;
  logic [DBIT-1:0]  r_b;
  logic [NB_OP-1:0] r_op;
  logic [DBIT-1:0]  r_result;

  // Opcode only uses the low NB_OP bits of the OP byte; the rest are dropped.
  logic w_unused_op_hi;
  assign w_unused_op_hi = ^bus.i_r_data[DBIT-1:NB_OP];

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic w_tmr_en;
  logic w_tmr_done;

  // Count only while stuck mid-frame on an empty FIFO; any pop or other state clears.
  assign w_tmr_en = is_mid_frame(r_state) && bus.i_rx_empty;

  uart_alu_ctrl_timer #(
    .TICKS (TIMEOUT_TICKS)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (!w_tmr_en),
    .i_en    (w_tmr_en),
    .o_done  (w_tmr_done)
  );

  assign w_timeout = w_tmr_en && w_tmr_done;
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (i_reset) r_state <= S_WAIT_A;
    else         r_state <= w_next_state;
  end

  // Next-state and strobe decode; pops/pushes are single-cycle per byte.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    w_next_state = r_state;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      S_WAIT_A: begin
        if (!bus.i_rx_empty) begin
          w_rd         = 1'b1;
          w_next_state = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (!bus.i_rx_empty) begin
          w_rd         = 1'b1;
          w_next_state = S_WAIT_OP;
        end else if (w_timeout) begin
          w_next_state = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (!bus.i_rx_empty) begin
          w_rd         = 1'b1;
          w_next_state = S_EXEC;
        end else if (w_timeout) begin
          w_next_state = S_WAIT_A;
        end
      end
      S_EXEC: w_next_state = S_SEND;
      S_SEND: begin
        if (!bus.i_tx_full) begin
          w_wr         = 1'b1;
          w_next_state = S_WAIT_A;
        end
      end
      default: w_next_state = S_WAIT_A;
    endcase
  end

  // Operand capture on each pop and result capture in the single EXEC cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: these are plain registers (not a memory array), so they are reset
    // to give the ALU and TX data a defined 0 right out of reset.
    if (i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      if (w_rd) begin
        case (r_state)
          S_WAIT_A:  r_a  <= bus.i_r_data;
          S_WAIT_B:  r_b  <= bus.i_r_data;
          S_WAIT_OP: r_op <= bus.i_r_data[NB_OP-1:0];
          default:   ;
        endcase
      end
      if (r_state == S_EXEC) r_result <= bus.i_alu_result;
    end
  end

  // Strobes are gated by reset: the state is S_WAIT_A during reset and would
  // otherwise pop a non-empty FIFO.
  assign bus.o_rd_uart = w_rd && !i_reset;
  assign bus.o_wr_uart = w_wr && !i_reset;
  assign bus.o_w_data  = r_result;
  assign bus.o_alu_a   = r_a;
  assign bus.o_alu_b   = r_b;
  assign bus.o_alu_op  = r_op;
  assign bus.o_busy    = (r_state != S_WAIT_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: behavioural RX/TX FIFO and ALU models,
// directed scenarios plus a randomized frame stream with TX back-pressure.
// Build with `define UART_ALU_CTRL_TIMEOUT_EN to add the timeout scenario.
module tb_uart_alu_ctrl;

  logic clk = 1'b0;
  logic rst;

  uart_alu_ctrl_if #(.DBIT(8), .NB_OP(6)) bus ();

  uart_alu_ctrl #(
    .DBIT  (8),
    .NB_OP (6)
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    , .TIMEOUT_TICKS (16)
`endif
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // External ALU model: result as plain modulo-256 arithmetic on the operands.
  function automatic logic [7:0] alu_model(input int a, input int b, input int op);
    int r;
    case (op)
      6'h20:   r = a + b;
      6'h22:   r = a - b + 256;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h27:   r = 255 - (a | b);
      default: r = a;
    endcase
    return 8'(r % 256);
  endfunction

  assign bus.i_alu_result = alu_model(int'(bus.o_alu_a), int'(bus.o_alu_b), int'(bus.o_alu_op));

  // Scoreboard state.
  logic [7:0] rx_q[$];
  int         pop_cyc[$];
  int         push_cyc[$];
  logic [7:0] push_data[$];
  logic [7:0] exp_q[$];
  int         cyc;
  int         n_checks;
  int         n_errors;
  int         n_viol;
  int         fall_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_rx();
    bus.i_rx_empty = (rx_q.size() == 0);
    bus.i_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    push_cyc.delete();
    push_data.delete();
  endtask

  // One clock: strobes are sampled mid-cycle, FIFO effects applied just after the edge.
  task automatic tick();
    logic       p, w;
    logic [7:0] d;
    @(negedge clk);
    p = bus.o_rd_uart;
    w = bus.o_wr_uart;
    d = bus.o_w_data;
    if (w && bus.i_tx_full) n_viol++;
    @(posedge clk);
    cyc++;
    #1;
    if (p) begin
      if (rx_q.size() == 0) n_viol++;
      else begin
        void'(rx_q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
    if (w) begin
      push_cyc.push_back(cyc);
      push_data.push_back(d);
    end
    refresh_rx();
  endtask

  task automatic wait_pushes(input int n, input int budget, input string tag);
    int k = 0;
    while (push_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_push_count"}, push_data.size(), n);
  endtask

  initial begin
    logic [7:0] a, b, op;
    n_checks = 0; n_errors = 0; n_viol = 0; cyc = 0;
    rst = 1'b1;
    bus.i_tx_full = 1'b0;
    refresh_rx();

    // Basic frame preloaded during reset: no pops while reset is high.
    repeat (2) tick();
    send(8'h05); send(8'h03); send(8'h20);
    tick();
    check("rst_rd", bus.o_rd_uart, 0);
    check("rst_wr", bus.o_wr_uart, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_a", bus.o_alu_a, 0);
    check("rst_b", bus.o_alu_b, 0);
    check("rst_op", bus.o_alu_op, 0);
    check("rst_wdata", bus.o_w_data, 0);
    check("rst_pops", pop_cyc.size(), 0);
    rst = 1'b0;
    clear_logs();
    wait_pushes(1, 50, "basic");
    check("basic_pops", pop_cyc.size(), 3);
    check("basic_pop1_adj", pop_cyc[1], pop_cyc[0] + 1);
    check("basic_pop2_adj", pop_cyc[2], pop_cyc[0] + 2);
    check("basic_a", bus.o_alu_a, 8'h05);
    check("basic_b", bus.o_alu_b, 8'h03);
    check("basic_op", bus.o_alu_op, 6'h20);
    check("basic_data", push_data[0], 8'h08);
    check("basic_latency", push_cyc[0], pop_cyc[2] + 2);
    repeat (2) tick();
    check("basic_idle_busy", bus.o_busy, 0);
    check("basic_one_push", push_data.size(), 1);

    // Bytes at serial spacing: state holds in the gaps, result wraps to 0.
    clear_logs();
    send(8'hFF);
    repeat (2604) tick();
    check("gap1_pops", pop_cyc.size(), 1);
    check("gap1_busy", bus.o_busy, 1);
    check("gap1_rd", bus.o_rd_uart, 0);
    send(8'h01);
    repeat (2604) tick();
    check("gap2_pops", pop_cyc.size(), 2);
    check("gap2_rd", bus.o_rd_uart, 0);
    send(8'h20);
    wait_pushes(1, 20, "gap");
    check("gap_data", push_data[0], 8'h00);
    check("gap_latency", push_cyc[0], pop_cyc[2] + 2);

    // TX full for 100 cycles at S_SEND with the next frame already queued.
    clear_logs();
    bus.i_tx_full = 1'b1;
    send(8'h0A); send(8'h04); send(8'h22);
    send(8'h09); send(8'h03); send(8'h26);
    repeat (5) tick();
    repeat (100) tick();
    check("stall_pushes", push_data.size(), 0);
    check("stall_pops", pop_cyc.size(), 3);
    check("stall_wr", bus.o_wr_uart, 0);
    check("stall_busy", bus.o_busy, 1);
    bus.i_tx_full = 1'b0;
    fall_edge = cyc + 1;
    wait_pushes(2, 30, "stall");
    check("stall_push_edge", push_cyc[0], fall_edge);
    check("stall_data0", push_data[0], 8'h06);
    check("stall_data1", push_data[1], 8'h0A);

    // Two frames back-to-back in the FIFO.
    clear_logs();
    send(8'h3C); send(8'h0F); send(8'h24);
    send(8'h55); send(8'hAA); send(8'h25);
    wait_pushes(2, 40, "b2b");
    check("b2b_pops", pop_cyc.size(), 6);
    check("b2b_data0", push_data[0], 8'h0C);
    check("b2b_data1", push_data[1], 8'hFF);
    check("b2b_restart", pop_cyc[3], push_cyc[0] + 1);

    // Reset after A is popped; next byte sits in the FIFO during reset.
    clear_logs();
    send(8'h11);
    for (int k = 0; k < 20 && pop_cyc.size() == 0; k++) tick();
    check("mid_popA", pop_cyc.size(), 1);
    rst = 1'b1;
    send(8'h22);
    repeat (2) tick();
    check("mid_rst_a", bus.o_alu_a, 0);
    check("mid_rst_b", bus.o_alu_b, 0);
    check("mid_rst_op", bus.o_alu_op, 0);
    check("mid_rst_wdata", bus.o_w_data, 0);
    check("mid_rst_rd", bus.o_rd_uart, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_pops", pop_cyc.size(), 1);
    rst = 1'b0;
    send(8'h33); send(8'h20);
    wait_pushes(1, 20, "mid");
    check("mid_a", bus.o_alu_a, 8'h22);
    check("mid_b", bus.o_alu_b, 8'h33);
    check("mid_data", push_data[0], 8'h55);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // Timeout after A: back to idle 16 cycles after the pop, then a fresh frame.
    clear_logs();
    send(8'h11);
    for (int k = 0; k < 20 && pop_cyc.size() == 0; k++) tick();
    check("tmo_popA", pop_cyc.size(), 1);
    repeat (15) tick();
    check("tmo_busy_15", bus.o_busy, 1);
    tick();
    check("tmo_busy_16", bus.o_busy, 0);
    check("tmo_no_push", push_data.size(), 0);
    check("tmo_a_kept", bus.o_alu_a, 8'h11);
    send(8'h07); send(8'h02); send(8'h22);
    wait_pushes(1, 20, "tmo");
    check("tmo_a", bus.o_alu_a, 8'h07);
    check("tmo_data", push_data[0], 8'h05);
`endif

    // Randomized frames with random inter-byte gaps and TX back-pressure.
    clear_logs();
    exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = {2'($urandom_range(0, 3)), 6'h20 + 6'($urandom_range(0, 7))};
      exp_q.push_back(alu_model(int'(a), int'(b), int'(op) % 64));
      for (int j = 0; j < 3; j++) begin
        send((j == 0) ? a : (j == 1) ? b : op);
        repeat ($urandom_range(0, 3)) begin
          bus.i_tx_full = ($urandom_range(0, 3) == 0);
          tick();
        end
      end
    end
    bus.i_tx_full = 1'b0;
    wait_pushes(12, 600, "rand");
    for (int i = 0; i < 12; i++) check($sformatf("rand_data%0d", i), push_data[i], exp_q[i]);
    check("rand_pops", pop_cyc.size(), 36);

    check("fifo_drained", rx_q.size(), 0);
    check("protocol_violations", n_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
